// File: rtl/ann_pkg.sv
// Shared definitions for the ANN layer datapath: sequencer state encoding,
// operand index widths and default memory read latency.
package ann_pkg;

    localparam int IN_W         = 7;
    localparam int NODE_W_DEF   = 5;
    localparam int COEF_AW_DEF  = 10;
    localparam int READ_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MAC,
        ST_DRAIN,
        ST_STORE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/ann_node_sequencer_if.sv
// Controller-to-datapath bundle of the node sequencer: layer geometry and start
// in, read/MAC/store strobes and the layer-done level out.
interface ann_node_sequencer_if
    import ann_pkg::*;
#(
    parameter int COEF_AW = COEF_AW_DEF,
    parameter int NODE_W  = NODE_W_DEF
);

    logic               reset_accum;
    logic               coeff_ready;
    logic [IN_W-1:0]    max_input;
    logic [NODE_W-1:0]  max_nodes;
    logic               rd_en;
    logic [IN_W-1:0]    in_addr;
    logic [COEF_AW-1:0] coef_addr;
    logic               mac_en;
    logic               mac_clear;
    logic               node_store;
    logic [NODE_W-1:0]  node_idx;
    logic               n_start_done;
    logic               busy;

    modport master (
        output reset_accum, coeff_ready, max_input, max_nodes,
        input  rd_en, in_addr, coef_addr, mac_en, mac_clear, node_store,
               node_idx, n_start_done, busy
    );

    modport slave (
        input  reset_accum, coeff_ready, max_input, max_nodes,
        output rd_en, in_addr, coef_addr, mac_en, mac_clear, node_store,
               node_idx, n_start_done, busy
    );

endinterface

// File: rtl/ann_valid_delay.sv
// Flushable shift register that delays a valid strobe by DEPTH cycles so it
// lines up with data returning from a fixed-latency memory.
module ann_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
        if (flush) begin
            sr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/ann_node_sequencer.sv
// Per-layer node sequencer: for each node clears the accumulator, streams operand
// and coefficient reads, waits out the read latency, then stores the result.
module ann_node_sequencer
    import ann_pkg::*;
#(
    parameter int READ_LAT = READ_LAT_DEF,
    parameter int COEF_AW  = COEF_AW_DEF,
    parameter int NODE_W   = NODE_W_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    ann_node_sequencer_if.slave  bus
);

    seq_state_t         state_q, state_d;
    logic [IN_W-1:0]    mi_q, mi_d;
    logic [NODE_W-1:0]  mn_q, mn_d;
    logic [NODE_W-1:0]  node_q, node_d;
    logic [IN_W-1:0]    in_q, in_d;
    logic [COEF_AW-1:0] coef_q, coef_d;
    logic [2:0]         drain_q, drain_d;

    logic rd_en;
    logic mac_clear;
    logic node_store;
    logic flush;
    logic mac_en;

    always_comb begin
        state_d    = state_q;
        mi_d       = mi_q;
        mn_d       = mn_q;
        node_d     = node_q;
        in_d       = in_q;
        coef_d     = coef_q;
        drain_d    = drain_q;
        rd_en      = 1'b0;
        mac_clear  = 1'b0;
        node_store = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mac_clear = 1'b1;
                in_d      = '0;
                drain_d   = '0;
                state_d   = (mi_q == '0) ? ST_DRAIN : ST_MAC;
            end
            ST_MAC: begin
                if (bus.coeff_ready) begin
                    rd_en  = 1'b1;
                    in_d   = in_q + IN_W'(1);
                    coef_d = coef_q + COEF_AW'(1);
                    if (in_q == mi_q - IN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Hold here until the last issued read has reached the MAC.
                if (drain_q == 3'(READ_LAT - 1)) begin
                    drain_d = '0;
                    state_d = ST_STORE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            ST_STORE: begin
                node_store = 1'b1;
                if (node_q == mn_q - NODE_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    node_d  = node_q + NODE_W'(1);
                    state_d = ST_CLEAR;
                end
            end
            default: begin
            end
        endcase

        // A start pulse wins over everything, including a store in flight, so an
        // aborted node never reaches the output slot.
        if (bus.reset_accum) begin
            rd_en      = 1'b0;
            node_store = 1'b0;
            flush      = 1'b1;
            mi_d       = bus.max_input;
            mn_d       = bus.max_nodes;
            node_d     = '0;
            in_d       = '0;
            coef_d     = '0;
            drain_d    = '0;
            state_d    = (bus.max_nodes == '0) ? ST_DONE : ST_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            mi_q    <= '0;
            mn_q    <= '0;
            node_q  <= '0;
            in_q    <= '0;
            coef_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            mi_q    <= mi_d;
            mn_q    <= mn_d;
            node_q  <= node_d;
            in_q    <= in_d;
            coef_q  <= coef_d;
            drain_q <= drain_d;
        end
    end

    ann_valid_delay #(
        .DEPTH (READ_LAT)
    ) u_mac_dly (
        .clk   (clk),
        .n_rst (n_rst),
        .flush (flush),
        .din   (rd_en),
        .dout  (mac_en)
    );

    assign bus.rd_en        = rd_en;
    assign bus.in_addr      = in_q;
    assign bus.coef_addr    = coef_q;
    assign bus.mac_en       = mac_en;
    assign bus.mac_clear    = mac_clear;
    assign bus.node_store   = node_store;
    assign bus.node_idx     = node_q;
    assign bus.n_start_done = (state_q == ST_DONE);
    assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_ann_node_sequencer.sv
// Scoreboard bench for ann_node_sequencer: each layer start pushes the expected
// reads, stores and done cycle; a negedge monitor pops and compares them.
module tb_ann_node_sequencer;

    localparam int RL = 1;

    typedef struct { int cyc; int idx; } store_t;
    typedef struct { int in_a; int coef; } rd_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    ann_node_sequencer_if #(.COEF_AW(10), .NODE_W(5)) bus ();

    ann_node_sequencer #(
        .READ_LAT (RL),
        .COEF_AW  (10),
        .NODE_W   (5)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit armed = 1'b0;
    int done_exp = 0;
    int mac_cnt = 0;
    int st_cnt = 0;
    int cur_mi = 0;
    int cur_mn = 0;
    logic rd_prev = 1'b0;
    logic done_prev = 1'b0;
    store_t st_q[$];
    rd_t    rd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: runs just after each falling edge, once inputs for the cycle are settled.
    always begin
        int rel;
        store_t s;
        rd_t r;
        @(negedge clk);
        #1;
        if (armed) begin
            rel = cyc - start_cyc + 1;
            if (bus.rd_en) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    check("in_addr", 32'(bus.in_addr), r.in_a);
                    check("coef_addr", 32'(bus.coef_addr), r.coef);
                end
            end
            if (bus.mac_en) begin
                mac_cnt++;
                check("mac_lat", 32'(rd_prev), 1);
                check("mac_overlap", 32'(bus.mac_clear | bus.node_store), 0);
            end
            if (bus.node_store) begin
                st_cnt++;
                if (st_q.size() == 0) begin
                    check("store_unexpected", 1, 0);
                end else begin
                    s = st_q.pop_front();
                    $display("store node %0d at cycle %0d", bus.node_idx, rel);
                    check("store_cycle", rel, s.cyc);
                    check("store_idx", 32'(bus.node_idx), s.idx);
                end
            end
            if (bus.n_start_done && !done_prev) begin
                check("done_cycle", rel, done_exp);
            end
        end
        rd_prev   = bus.rd_en;
        done_prev = bus.n_start_done;
    end

    task automatic start_layer(input int mi, input int mn, input int stall_node, input int stall_len);
        store_t s;
        rd_t r;
        @(negedge clk);
        armed = 1'b0;
        bus.reset_accum = 1'b1;
        bus.max_input = 7'(mi);
        bus.max_nodes = 5'(mn);
        st_q.delete();
        rd_q.delete();
        mac_cnt = 0;
        st_cnt  = 0;
        cur_mi  = mi;
        cur_mn  = mn;
        for (int n = 0; n < mn; n++) begin
            for (int i = 0; i < mi; i++) begin
                r.in_a = i;
                r.coef = (n * mi + i) % 1024;
                rd_q.push_back(r);
            end
            s.cyc = (n + 1) * (mi + RL + 2) + ((n >= stall_node) ? stall_len : 0);
            s.idx = n;
            st_q.push_back(s);
        end
        done_exp = (mn == 0) ? 1 : mn * (mi + RL + 2) + 1 + stall_len;
        $display("layer start mi=%0d mn=%0d expect done at cycle %0d", mi, mn, done_exp);
        @(negedge clk);
        start_cyc = cyc;
        armed = 1'b1;
        bus.reset_accum = 1'b0;
        // Geometry changes after the latch must be ignored.
        bus.max_input = 7'($urandom);
        bus.max_nodes = 5'($urandom);
        #2;
        if (mn != 0) check("wait_entry_done_low", 32'(bus.n_start_done), 0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.n_start_done) break;
            @(negedge clk);
            #2;
        end
        check("done_seen", 32'(bus.n_start_done), 1);
        check("mac_count", mac_cnt, cur_mi * cur_mn);
        check("store_count", st_cnt, cur_mn);
        check("rd_left", rd_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.reset_accum = 1'b0;
        bus.coeff_ready = 1'b1;
        bus.max_input   = '0;
        bus.max_nodes   = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.n_start_done), 0);
        check("rst_rd_en", 32'(bus.rd_en), 0);
        check("rst_coef", 32'(bus.coef_addr), 0);
        check("rst_node", 32'(bus.node_idx), 0);
        check("rst_mac_en", 32'(bus.mac_en), 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Nominal 16x4 layer, done held afterwards
        start_layer(16, 4, 99, 0);
        wait_done(200);
        repeat (3) @(negedge clk);
        #2;
        check("done_held", 32'(bus.n_start_done), 1);

        // Stall of 3 cycles in node 1 (MAC starts cycle 21, drop covers 25..27)
        start_layer(16, 4, 1, 3);
        repeat (24) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            bus.coeff_ready = 1'b0;
            #2;
            check("stall_rd_en", 32'(bus.rd_en), 0);
            check("stall_coef_hold", 32'(bus.coef_addr), 20);
            check("stall_in_hold", 32'(bus.in_addr), 4);
        end
        @(negedge clk);
        bus.coeff_ready = 1'b1;
        wait_done(200);

        // Zero inputs per node
        start_layer(0, 2, 99, 0);
        wait_done(50);

        // Abort in the middle of node 2, full sequence restarts
        start_layer(16, 4, 99, 0);
        repeat (44) @(negedge clk);
        start_layer(16, 4, 99, 0);
        check("abort_node_restart", 32'(bus.node_idx), 0);
        check("abort_coef_restart", 32'(bus.coef_addr), 0);
        wait_done(200);

        // Asynchronous reset in MAC
        start_layer(16, 4, 99, 0);
        repeat (10) @(negedge clk);
        armed = 1'b0;
        #3;
        n_rst = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_rd_en", 32'(bus.rd_en), 0);
        check("arst_coef", 32'(bus.coef_addr), 0);
        check("arst_in", 32'(bus.in_addr), 0);
        check("arst_done", 32'(bus.n_start_done), 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("arst_no_done", 32'(bus.n_start_done), 0);
        check("arst_idle", 32'(bus.busy), 0);

        // Empty layer
        start_layer(3, 0, 99, 0);
        wait_done(10);

        // Controller model: three consecutive layers
        start_layer(16, 4, 99, 0);
        wait_done(200);
        start_layer(4, 10, 99, 0);
        wait_done(200);
        start_layer(10, 10, 99, 0);
        wait_done(400);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ann_node_sequencer.md
Name: ann_node_sequencer

Overview:
- Per-layer datapath sequencer directly downstream of the ANN layer controller.
- On the controller's reset_accum pulse it latches the layer geometry (max_input, max_nodes). For each node in turn it then:
  - clears the MAC accumulator;
  - streams input-register and coefficient-memory read addresses;
  - gates the MAC with a latency-matched enable;
  - stores the node result.
- Raises n_start_done when the whole layer is finished. The controller waits on this signal before advancing to the next layer.

Parameters:
- READ_LAT, 1, read latency in cycles of the input register file and coefficient memory (1..4).
- COEF_AW, 10, coefficient address width.
- NODE_W, 5, node index width.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- reset_accum  in  1  start pulse from the controller; also aborts and restarts a layer in progress
- coeff_ready  in  1  coefficients valid; while low, no new reads are issued (stall)
- max_input  in  7  inputs per node for this layer; sampled on reset_accum
- max_nodes  in  NODE_W  nodes in this layer; sampled on reset_accum
- rd_en  out  1  read strobe to the input register file and coefficient memory
- in_addr  out  7  input operand index
- coef_addr  out  COEF_AW  coefficient address
- mac_en  out  1  MAC accumulate enable; equals rd_en delayed by READ_LAT cycles
- mac_clear  out  1  zero the accumulator
- node_store  out  1  write the accumulator result to the node output slot node_idx
- node_idx  out  NODE_W  current node
- n_start_done  out  1  layer complete; level signal
- busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset: state IDLE. Every output is 0, all counters are 0 and the delay line is cleared.
- States: IDLE, CLEAR, MAC, DRAIN, STORE, DONE.
- reset_accum sampled high in any state:
  - latch max_input → mi_q and max_nodes → mn_q;
  - zero node_idx, in_idx and coef_addr, and flush the mac_en delay line;
  - next state is CLEAR, or DONE if max_nodes == 0.
  - An abort is silent: no node_store is issued for the interrupted node.
- CLEAR (1 cycle): mac_clear = 1 and in_idx = 0. Next state is MAC, or DRAIN if mi_q == 0.
- MAC:
  - When coeff_ready == 1: rd_en = 1, in_addr = in_idx, coef_addr as held; then in_idx and coef_addr each increment by 1.
  - The issue with in_idx == mi_q-1 moves to DRAIN.
  - When coeff_ready == 0: rd_en = 0 and the counters hold.
- DRAIN: lasts exactly READ_LAT cycles, so the last mac_en pulse falls inside it. Next state is STORE.
- STORE (1 cycle): node_store = 1 with the current node_idx.
  - If node_idx == mn_q-1, next state is DONE.
  - Otherwise node_idx increments and the next state is CLEAR.
- DONE: n_start_done = 1, held until the next reset_accum or reset.
  - Because it is cleared on the reset_accum edge, the controller's following wait state sees it low.
- coef_addr counts continuously across the nodes of a layer (node-major layout, node*mi_q + input). It wraps modulo 2^COEF_AW and resets only on reset_accum or n_rst.
- mac_en is a READ_LAT-deep shift of rd_en. mac_en never coincides with mac_clear or node_store.
- Timing, counting from the cycle after reset_accum is sampled as cycle 1:
  - each node takes 1 + mi_q + READ_LAT + 1 cycles, plus any stall cycles;
  - n_start_done rises in cycle mn_q*(mi_q+READ_LAT+2)+1.
- An mi_q == 0 node stores a cleared (zero) accumulator.
- Changes on max_input or max_nodes after the latch have no effect.

Decomposition:
- ann_pkg holds the state enum typedef, the READ_LAT default and the input/node index widths. It is shared with the controller for the max_input width.
- One sub-module, ann_valid_delay: a parameterised shift register with flush, used to generate mac_en.

Test Plan:
- Nominal layer: READ_LAT=1, reset_accum with max_input=16, max_nodes=4, coeff_ready=1.
  - n_start_done rises in cycle 77.
  - 4 node_store pulses occur in cycles 19, 38, 57 and 76.
  - coef_addr runs 0..63 with no gaps.
  - 64 mac_en pulses, each one cycle after its rd_en.
- Stall: same layer, coeff_ready dropped for 3 cycles mid-node 1.
  - rd_en is low during the drop and the addresses hold.
  - Done is delayed by exactly 3 cycles, to cycle 80.
  - The mac_en count is still 64.
- Boundaries:
  - max_nodes=0 → n_start_done high in cycle 1, with no rd_en and no node_store.
  - max_input=0, max_nodes=2 → the sequence CLEAR, DRAIN, STORE runs twice; zero rd_en; done in cycle 7 (READ_LAT=1).
- Abort: reset_accum reasserted mid-node 2 of a 16×4 layer.
  - The mac_en pipeline is flushed; node_idx and coef_addr restart at 0.
  - The full 77-cycle sequence repeats from that edge.
- Async reset: n_rst pulsed low during MAC.
  - All outputs go to 0 immediately, independent of clk; state is IDLE.
  - No n_start_done until a new reset_accum.
- Controller handshake: full sequence of three layers (16×4, 4×10, 10×10) driven by the layer controller model.
  - n_start_done is low at every WAIT_LAYER entry.
  - Each layer completes with the correct store count (4, 10, 10).
